// File: rtl/mult_div_unit.sv
// mult_div_unit
//
// Iterative MULT/MULTU/DIV/DIVU engine for the multi-cycle MIPS datapath.
// Operands arrive from the inter-stage temp registers. One result bit is
// produced per clock:
//   - multiply uses radix-2 shift-add
//   - divide uses restoring division
// Signed operations run on magnitudes. The signs are restored in a final
// FIX cycle that also writes the HI/LO pair read by MFHI/MFLO.
//
// Ports
//   CLK    rising-edge system clock
//   RST    asynchronous active-low reset
//   Start  request an operation (sampled only while idle)
//   Op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A      multiplicand / dividend (rs)
//   B      multiplier / divisor (rt)
//   Busy   high while an operation is in flight
//   Done   one-cycle pulse after HI/LO have been updated
//   HI     product upper half, or remainder
//   LO     product lower half, or quotient

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   count;
    // acc: upper product half (one extra carry bit), or partial remainder.
    logic [WIDTH:0]     acc;
    // work: multiplier being shifted out, or dividend shifting into quotient.
    logic [WIDTH-1:0]   work;
    // opnd: multiplicand, or divisor.
    logic [WIDTH-1:0]   opnd;
    logic               res_neg;
    logic               rem_neg;
    logic               b_zero;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes.
    // Negating the most negative value wraps back to itself. Read as
    // unsigned, that is still the correct magnitude, so MIN needs no
    // special case anywhere downstream.
    always_comb begin
        a_abs = (Op[0] && A[WIDTH-1]) ? -A : A;
        b_abs = (Op[0] && B[WIDTH-1]) ? -B : B;
    end

    // Single iteration datapaths, plus sign restoration for the FIX cycle.
    always_comb begin
        mul_sum  = acc + {1'b0, (work[0] ? opnd : {WIDTH{1'b0}})};
        rem_sh   = {acc[WIDTH-1:0], work[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, opnd};
        rem_ge   = (rem_sh >= {1'b0, opnd});
        product  = {acc[WIDTH-1:0], work};
        prod_fix = res_neg ? -product : product;
        quot_fix = res_neg ? -work : work;
        rem_fix  = rem_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Control FSM and datapath registers.
    //
    // A zero divisor is not special-cased during CALC. Restoring division
    // by zero leaves the remainder equal to |A|, so restoring the
    // dividend's sign gives back A exactly as presented. Only the quotient
    // needs forcing to all ones.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            count   <= '0;
            acc     <= '0;
            work    <= '0;
            opnd    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            b_zero  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_q    <= Op;
                        res_neg <= Op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rem_neg <= Op[0] & A[WIDTH-1];
                        b_zero  <= (B == {WIDTH{1'b0}});
                        acc     <= '0;
                        count   <= '0;
                        if (Op[1]) begin
                            work <= a_abs;
                            opnd <= b_abs;
                        end else begin
                            work <= b_abs;
                            opnd <= a_abs;
                        end
                        Busy  <= 1'b1;
                        state <= CALC;
                    end
                end

                CALC: begin
                    count <= count + 1'b1;
                    if (op_q[1]) begin
                        acc  <= rem_ge ? rem_sub : rem_sh;
                        work <= {work[WIDTH-2:0], rem_ge};
                    end else begin
                        acc  <= {1'b0, mul_sum[WIDTH:1]};
                        work <= {mul_sum[0], work[WIDTH-1:1]};
                    end
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (op_q[1]) begin
                        HI <= rem_fix;
                        LO <= b_zero ? {WIDTH{1'b1}} : quot_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit (WIDTH = 32).
// Contents:
//   - a table of directed vectors with hand-computed results
//   - hand-written sequences for busy-ignore, back-to-back start and
//     mid-operation reset
//   - randomized operations checked against a 64-bit arithmetic model

module tb_mult_div_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    always #5 CLK = ~CLK;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    // Reference model: plain 64-bit arithmetic, {HI, LO}.
    function automatic logic [63:0] refModel(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = {32'b0, a} * {32'b0, b};
            2'b01: res = 64'(sa * sb);
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else if (op == 2'b10) begin
                    res = {a % b, a / b};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h00000000;
            1:       v = 32'h00000001;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'h80000000;
            4:       v = 32'h7FFFFFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name,
                               input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive an operation and let the next rising edge accept it.
    // Returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    // Count edges until Done is seen, bounded at 100.
    // busyCycles also includes the sample taken on entry.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = Busy ? 1 : 0;
        while (!Done && cycles < 100) begin
            @(posedge CLK);
            #1;
            cycles++;
            if (Busy) busyCycles++;
        end
    endtask

    task automatic runAndCheck(input string tag,
                               input logic [1:0] op,
                               input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [31:0] expHi,
                               input logic [31:0] expLo);
        int cyc;
        int bcyc;
        applyStimulus(op, a, b);
        checkOutput({tag, " done low after start"}, 64'(Done), 64'd0);
        waitDone(cyc, bcyc);
        checkOutput({tag, " latency"}, 64'(cyc), 64'd33);
        checkOutput({tag, " busy cycles"}, 64'(bcyc), 64'd33);
        checkOutput({tag, " HI"}, 64'(HI), 64'(expHi));
        checkOutput({tag, " LO"}, 64'(LO), 64'(expLo));
    endtask

    initial begin
        int          cyc;
        int          bcyc;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{2'b10, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA};

        RST   = 1'b0;
        Start = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset Busy", 64'(Busy), 64'd0);
        checkOutput("reset Done", 64'(Done), 64'd0);
        checkOutput("reset HI", 64'(HI), 64'd0);
        checkOutput("reset LO", 64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                        vecs[i].expHi, vecs[i].expLo);
        end

        // A new Start while busy is ignored, as are operand/Op changes.
        applyStimulus(2'b00, 32'd6, 32'd7);
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        Op    = 2'b11;
        A     = 32'd1000;
        B     = 32'd3;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        waitDone(cyc, bcyc);
        checkOutput("ignore latency", 64'(cyc + 10), 64'd33);
        checkOutput("ignore HI", 64'(HI), 64'd0);
        checkOutput("ignore LO", 64'(LO), 64'd42);

        // Start in the Done cycle is accepted (back-to-back).
        runAndCheck("b2b", 2'b10, 32'd42, 32'd5, 32'd2, 32'd8);

        // Asynchronous reset mid-operation.
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'd2);
        repeat (14) begin
            @(posedge CLK);
            #1;
        end
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async reset Busy", 64'(Busy), 64'd0);
        checkOutput("async reset Done", 64'(Done), 64'd0);
        checkOutput("async reset HI", 64'(HI), 64'd0);
        checkOutput("async reset LO", 64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        runAndCheck("after reset", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3);

        // Randomized operations against the reference model.
        for (int n = 0; n < 1000; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            exp = refModel(rop, ra, rb);
            runAndCheck($sformatf("rand%0d op%0d a=%h b=%h", n, rop, ra, rb),
                        rop, ra, rb, exp[63:32], exp[31:0]);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK);
                #1;
                checkOutput("done pulse width", 64'(Done), 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
